// File: rtl/div_dispatch_ctrl.sv
// Dispatch controller for a pool of div_cluster units: round-robin job issue,
// per-unit IDLE/BUSY/DONE tracking with tags, and round-robin result return.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module div_dispatch_ctrl #(
   parameter int DIV_COUNT = 4,
   parameter int TAG_SIZE  = `TAG_SIZE,
   localparam int IDX_W = $clog2(DIV_COUNT),
   localparam int CNT_W = $clog2(DIV_COUNT + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 job_valid,
   input  logic [TAG_SIZE-1:0]  job_tag,
   output logic                 job_ready,
   input  logic [DIV_COUNT-1:0] div_ready,
   input  logic [DIV_COUNT-1:0] div_valid,
   output logic [DIV_COUNT-1:0] div_start,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [IDX_W-1:0]     res_sel,
   output logic [TAG_SIZE-1:0]  res_tag,
   output logic [CNT_W-1:0]     inflight,
   output logic                 err_spurious
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [DIV_COUNT-1:0] is_idle;
   logic [DIV_COUNT-1:0] is_busy;
   logic [DIV_COUNT-1:0] is_done;
   logic [DIV_COUNT-1:0] idle_next;
   logic [DIV_COUNT-1:0] eligible;
   logic [TAG_SIZE-1:0]  unit_tag [DIV_COUNT];

   logic [IDX_W-1:0] dptr_reg;
   logic [IDX_W-1:0] rptr_reg;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] rr_idx;
   logic [IDX_W-1:0] lock_idx_reg;
   logic             grant_found;
   logic             rr_found;
   logic             lock_reg;
   logic             err_reg;
   logic             issue;
   logic             accept;
   logic [CNT_W-1:0] inflight_reg;
   logic [CNT_W-1:0] inflight_next;

   // First set bit of req at or above ptr, wrapping modulo DIV_COUNT; MSB = found.
   function automatic logic [IDX_W:0] rr_pick(input logic [DIV_COUNT-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
      logic [IDX_W:0]   p;
      logic             found;
      logic [IDX_W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < DIV_COUNT; k++) begin
         p = {1'b0, ptr} + (IDX_W+1)'(k);
         if (p >= (IDX_W+1)'(DIV_COUNT))
            p = p - (IDX_W+1)'(DIV_COUNT);
         if (!found && req[p[IDX_W-1:0]]) begin
            found = 1'b1;
            idx   = p[IDX_W-1:0];
         end
      end
      return {found, idx};
   endfunction

   assign eligible                 = is_idle & div_ready;
   assign {grant_found, grant_idx} = rr_pick(eligible, dptr_reg);
   assign {rr_found, rr_idx}       = rr_pick(is_done, rptr_reg);

   assign job_ready = !reset && grant_found;
   assign issue     = job_valid && job_ready;
   assign div_start = issue ? (DIV_COUNT'(1) << grant_idx) : '0;

   // Once a result has been offered and stalled, the selection is frozen so a
   // later-finishing unit nearer rptr cannot steal the slot.
   assign res_valid    = !reset && rr_found;
   assign res_sel      = lock_reg ? lock_idx_reg : rr_idx;
   assign res_tag      = unit_tag[res_sel];
   assign accept       = res_valid && res_ready;
   assign inflight     = inflight_reg;
   assign err_spurious = err_reg;

   for (genvar gi = 0; gi < DIV_COUNT; gi++) begin : g_unit
      logic [1:0]          state_reg;
      logic [1:0]          state_next;
      logic [TAG_SIZE-1:0] tag_reg;

      always_comb begin
         state_next = state_reg;
         if (issue && grant_idx == IDX_W'(gi))
            state_next = ST_BUSY;
         else if (state_reg == ST_BUSY && div_valid[gi])
            state_next = ST_DONE;
         else if (accept && res_sel == IDX_W'(gi))
            state_next = ST_IDLE;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state_reg <= ST_IDLE;
            tag_reg   <= '0;
         end else begin
            state_reg <= state_next;
            if (issue && grant_idx == IDX_W'(gi))
               tag_reg <= job_tag;
         end
      end

      assign is_idle[gi]   = (state_reg == ST_IDLE);
      assign is_busy[gi]   = (state_reg == ST_BUSY);
      assign is_done[gi]   = (state_reg == ST_DONE);
      assign idle_next[gi] = (state_next == ST_IDLE);
      assign unit_tag[gi]  = tag_reg;
   end

   always_comb begin
      inflight_next = '0;
      for (int i = 0; i < DIV_COUNT; i++)
         inflight_next = inflight_next + CNT_W'(!idle_next[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dptr_reg     <= '0;
         rptr_reg     <= '0;
         inflight_reg <= '0;
         err_reg      <= 1'b0;
         lock_reg     <= 1'b0;
         lock_idx_reg <= '0;
      end else begin
         if (issue)
            dptr_reg <= (grant_idx == IDX_W'(DIV_COUNT - 1)) ? '0 : grant_idx + IDX_W'(1);
         if (accept)
            rptr_reg <= (res_sel == IDX_W'(DIV_COUNT - 1)) ? '0 : res_sel + IDX_W'(1);
         inflight_reg <= inflight_next;
         if (|(div_valid & ~is_busy))
            err_reg <= 1'b1;
         lock_reg     <= res_valid && !res_ready;
         lock_idx_reg <= res_sel;
      end
   end

endmodule

// File: tb/tb_div_dispatch_ctrl.sv
// Directed bench for div_dispatch_ctrl; expected results go to a queue that a
// negedge monitor drains whenever a result is accepted.
module tb_div_dispatch_ctrl;

   logic       clk;
   logic       reset;
   logic       job_valid;
   logic [7:0] job_tag;
   logic       job_ready;
   logic [3:0] div_ready;
   logic [3:0] div_valid;
   logic [3:0] div_start;
   logic       res_valid;
   logic       res_ready;
   logic [1:0] res_sel;
   logic [7:0] res_tag;
   logic [2:0] inflight;
   logic       err_spurious;

   int         n_chk;
   int         n_fail;
   logic [9:0] exp_q[$];
   logic [9:0] exp_item;

   div_dispatch_ctrl #(.DIV_COUNT(4), .TAG_SIZE(8)) dut (
      .clk(clk),
      .reset(reset),
      .job_valid(job_valid),
      .job_tag(job_tag),
      .job_ready(job_ready),
      .div_ready(div_ready),
      .div_valid(div_valid),
      .div_start(div_start),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_sel(res_sel),
      .res_tag(res_tag),
      .inflight(inflight),
      .err_spurious(err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic issue_jobs(input int n, input logic [7:0] base);
      job_valid = 1'b1;
      for (int t = 0; t < n; t++) begin
         job_tag = base + 8'(t);
         tick();
      end
      job_valid = 1'b0;
   endtask

   // Scoreboard monitor: one line per accepted result.
   always @(negedge clk) begin
      if (!reset && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got sel=%0d tag=%0h required none", res_sel, res_tag);
         end else begin
            exp_item = exp_q.pop_front();
            $display("result sel=%0d tag=%0h (expected sel=%0d tag=%0h)",
                     res_sel, res_tag, exp_item[9:8], exp_item[7:0]);
            chk("result_sel", 32'(res_sel), 32'(exp_item[9:8]));
            chk("result_tag", 32'(res_tag), 32'(exp_item[7:0]));
         end
      end
   end

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      reset     = 1'b1;
      job_valid = 1'b0;
      job_tag   = 8'h00;
      div_ready = 4'hF;
      div_valid = 4'h0;
      res_ready = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_div_start", 32'(div_start), 0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_err", 32'(err_spurious), 0);
      chk("rst_job_ready", 32'(job_ready), 0);
      reset = 1'b0;
      #1;
      chk("post_rst_job_ready", 32'(job_ready), 1);

      // Single job
      job_valid = 1'b1;
      job_tag   = 8'h05;
      #1;
      chk("single_div_start", 32'(div_start), 32'h1);
      tick();
      job_valid = 1'b0;
      #1;
      chk("single_inflight", 32'(inflight), 1);
      chk("single_no_res", 32'(res_valid), 0);
      repeat (9) tick();
      div_valid = 4'b0001;
      tick();
      div_valid = 4'b0000;
      exp_q.push_back({2'd0, 8'h05});
      #1;
      chk("single_res_valid", 32'(res_valid), 1);
      chk("single_res_sel", 32'(res_sel), 0);
      chk("single_res_tag", 32'(res_tag), 32'h05);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      chk("single_inflight_end", 32'(inflight), 0);
      chk("single_res_gone", 32'(res_valid), 0);

      // Saturation
      do_reset();
      job_valid = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         job_tag = 8'(t);
         #1;
         chk("sat_div_start", 32'(div_start), 32'(1) << (t - 1));
         tick();
      end
      job_tag = 8'h05;
      #1;
      chk("sat_job_ready", 32'(job_ready), 0);
      chk("sat_div_start_idle", 32'(div_start), 0);
      chk("sat_inflight", 32'(inflight), 4);
      div_valid = 4'b0001;
      tick();
      div_valid = 4'b0000;
      exp_q.push_back({2'd0, 8'h01});
      res_ready = 1'b1;
      #1;
      chk("sat_res_sel", 32'(res_sel), 0);
      chk("sat_no_same_cycle_grant", 32'(job_ready), 0);
      tick();
      res_ready = 1'b0;
      #1;
      chk("sat_refill_ready", 32'(job_ready), 1);
      chk("sat_refill_start", 32'(div_start), 32'h1);
      tick();
      job_valid = 1'b0;
      #1;
      chk("sat_refill_inflight", 32'(inflight), 4);

      // Simultaneous done on units 1 and 3
      do_reset();
      issue_jobs(4, 8'h10);
      div_valid = 4'b1010;
      tick();
      div_valid = 4'b0000;
      exp_q.push_back({2'd1, 8'h11});
      exp_q.push_back({2'd3, 8'h13});
      res_ready = 1'b1;
      #1;
      chk("simul_first_sel", 32'(res_sel), 1);
      tick();
      chk("simul_second_valid", 32'(res_valid), 1);
      chk("simul_second_sel", 32'(res_sel), 3);
      tick();
      res_ready = 1'b0;
      #1;
      chk("simul_drained", 32'(res_valid), 0);
      chk("simul_inflight", 32'(inflight), 2);

      // Backpressure on unit 2, with unit 0 finishing while stalled
      div_valid = 4'b0100;
      tick();
      div_valid = 4'b0000;
      exp_q.push_back({2'd2, 8'h12});
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("bp_res_valid", 32'(res_valid), 1);
         chk("bp_res_sel", 32'(res_sel), 2);
         chk("bp_res_tag", 32'(res_tag), 32'h12);
         if (i == 2)
            div_valid = 4'b0001;
         tick();
         div_valid = 4'b0000;
      end
      exp_q.push_back({2'd0, 8'h10});
      res_ready = 1'b1;
      #1;
      chk("bp_release_sel", 32'(res_sel), 2);
      tick();
      chk("bp_next_sel", 32'(res_sel), 0);
      tick();
      res_ready = 1'b0;
      #1;
      chk("bp_drained", 32'(res_valid), 0);
      chk("bp_inflight", 32'(inflight), 0);

      // Wrap and skip: dptr=3 with only units 1 and 2 ready
      do_reset();
      issue_jobs(3, 8'h20);
      div_valid = 4'b0111;
      tick();
      div_valid = 4'b0000;
      exp_q.push_back({2'd0, 8'h20});
      exp_q.push_back({2'd1, 8'h21});
      exp_q.push_back({2'd2, 8'h22});
      res_ready = 1'b1;
      repeat (3) tick();
      res_ready = 1'b0;
      div_ready = 4'b0110;
      job_valid = 1'b1;
      job_tag   = 8'h42;
      #1;
      chk("wrap_grant", 32'(div_start), 32'h2);
      tick();
      div_ready = 4'hF;
      job_tag   = 8'h43;
      #1;
      chk("wrap_dptr_next", 32'(div_start), 32'h4);
      tick();
      job_valid = 1'b0;

      // Reset mid-run with three units busy
      do_reset();
      issue_jobs(3, 8'h30);
      #1;
      chk("midrst_inflight_before", 32'(inflight), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("midrst_inflight", 32'(inflight), 0);
      chk("midrst_res_valid", 32'(res_valid), 0);
      chk("midrst_err_clear", 32'(err_spurious), 0);
      res_ready = 1'b1;
      div_valid = 4'b0010;
      tick();
      div_valid = 4'b0000;
      #1;
      chk("midrst_err_set", 32'(err_spurious), 1);
      chk("midrst_no_result", 32'(res_valid), 0);
      repeat (3) tick();
      res_ready = 1'b0;

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
